sdram_cmd_dispatch: RTL
=======================

Name: sdram_cmd_dispatch

Overview:
- Front-end command dispatcher of the SDRAM controller. Accepts single-word host read/write requests and issues ACTIVE to open the row.
- Hands the column phase to the single read / single write-with-auto-precharge sequence FSMs over a level start/done handshake.
- Owns the SDRAM command/address bus, enforces tRCD/tRP/tRFC spacing and schedules periodic AUTO REFRESH.
- Power-up initialisation belongs to a separate block that signals completion on init_done.

Parameters:
- T_RCD, 2, ACTIVE-to-column-command spacing in clk cycles (>=1).
- T_RP, 2, cycles after sub-sequencer release before next ACTIVE/REFRESH (>=1).
- T_RFC, 7, cycles after AUTO REFRESH before next command (>=1).
- REF_INTERVAL, 780, cycles between refresh requests (>=T_RFC+8).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous, active-low reset
- init_done  in  1  high once the power-up sequence is complete; level
- req_valid  in  1  host request valid
- req_write  in  1  1=write, 0=read
- req_addr  in  22  {bank[21:20], row[19:8], col[7:0]}
- req_ready  out  1  request accepted on a cycle where req_valid&&req_ready
- busy  out  1  state != IDLE
- wr_start  out  1  level start to the write-AP sequencer
- wr_done  in  1  write sequencer done (level)
- wr_chip  in  1  write sequencer data-phase strobe
- rd_start  out  1  level start to the read sequencer
- rd_done  in  1  read sequencer done (level)
- rd_chip  in  1  read sequencer data-phase strobe
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
- sdram_addr  out  12  SDRAM A[11:0]
- sdram_ba  out  2  SDRAM bank address

Behaviour:
- Command encodings:
  - NOP 4'b0111
  - ACTIVE 4'b0011
  - READ 4'b0101
  - WRITE 4'b0100
  - AUTO_REFRESH 4'b0001
- Reset: state IDLE, sdram_cmd=NOP, sdram_addr=0, sdram_ba=0, wr_start=rd_start=0, busy=0, latched request cleared, refresh_pending=0, refresh counter loaded with REF_INTERVAL-1.
- Reset mid-operation aborts immediately to these values. There is no recovery sequence; the init block re-runs.
- req_ready = (state==IDLE) && init_done && !refresh_pending. It is combinational.
- On acceptance, bank/row/col/write are registered.
- States:
  - IDLE: if refresh_pending && init_done -> REFRESH; else on accept -> ACTIVATE.
  - ACTIVATE (1 cycle): cmd=ACTIVE, addr=row, ba=bank; -> TRCD_WAIT.
  - TRCD_WAIT: NOP for T_RCD-1 cycles (0 cycles when T_RCD=1); -> WR_SEQ or RD_SEQ per latched write bit.
  - WR_SEQ: wr_start=1. While wr_chip=1: cmd=WRITE, addr={1'b0,A10=1,2'b00,col}, ba=bank; otherwise NOP. On wr_done=1 -> RELEASE.
  - RD_SEQ: same as WR_SEQ with rd_start, rd_chip and READ (A10=1, auto-precharge).
  - RELEASE: both starts low, NOP; wait until the active sequencer's done=0; -> TRP_WAIT.
  - TRP_WAIT: NOP for T_RP cycles; -> IDLE.
  - REFRESH (1 cycle): cmd=AUTO_REFRESH, clears refresh_pending; -> TRFC_WAIT.
  - TRFC_WAIT: NOP for T_RFC cycles; -> IDLE.
- Outputs are registered (Moore). The command for a state appears in the cycle the state is current.
- Accept-to-ACTIVE latency is 1 cycle.
- Only one of wr_start/rd_start is ever high. A done from the inactive sequencer is ignored.
- A *_chip pulse outside WR_SEQ/RD_SEQ is ignored (NOP is driven).
- Refresh timer:
  - Held at REF_INTERVAL-1 while init_done=0.
  - Otherwise decrements each cycle. At 0 it sets refresh_pending and reloads.
  - Expiry while refresh_pending is already set leaves it set; there is no backlog count.
  - Expiry in the same cycle as an AUTO_REFRESH issue leaves pending=1.
- Refresh never pre-empts an in-flight access. It waits for IDLE.
- A shared wait counter (width to fit max(T_RCD,T_RP,T_RFC)) is reloaded on every state entry.

Decomposition:
- Package sdram_pkg:
  - command encoding constants and a 4-bit command typedef;
  - dispatcher state enum;
  - address-field width constants (BA=2, ROW=12, COL=8).
- Sub-module sdram_refresh_timer holds the counter and refresh_pending flag.
  - Inputs: clk, n_rst, enable (init_done), ack (refresh issued).
  - Output: refresh_pending.

Test Plan:
- Write: init_done=1, req_valid=1, req_write=1, req_addr=22'h2_ABC_45, with a model write-AP sequencer (DATA the cycle after start, WAIT, DONE) -> ACTIVE ba=2 addr=12'hABC one cycle after accept; NOP; wr_start; WRITE with addr=12'h445 ba=2 on the wr_chip cycle; start drops after done; 2 NOPs (T_RP); req_ready=1 again.
- Read: same address with req_write=0 -> READ addr=12'h445 on rd_chip; wr_start stays 0 throughout.
- Refresh: REF_INTERVAL=20, no requests -> refresh_pending at cycle 20; AUTO_REFRESH next cycle; 7 NOPs; req_ready low the whole time.
- Collision: refresh expires during WR_SEQ -> write completes with RELEASE and TRP_WAIT; REFRESH issued immediately from IDLE; a pending req_valid is accepted only after TRFC_WAIT.
- Handshake: hold wr_done=1 for 5 cycles after start drops -> dispatcher stays in RELEASE with NOP; TRP_WAIT starts only once wr_done=0.
- Reset: assert n_rst=0 in TRCD_WAIT -> same cycle sdram_cmd=NOP, starts=0, busy=0; refresh timer restarts from REF_INTERVAL-1 after release.

Source files
------------

// File: rtl/sdram_cmd_dispatch_pkg.sv
// Shared types for the SDRAM command dispatcher: bus command encodings,
// dispatcher state encoding and address field widths.
package sdram_pkg;

  typedef logic [3:0] sdram_cmd_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam sdram_cmd_t CMD_NOP          = 4'b0111;
  localparam sdram_cmd_t CMD_ACTIVE       = 4'b0011;
  localparam sdram_cmd_t CMD_READ         = 4'b0101;
  localparam sdram_cmd_t CMD_WRITE        = 4'b0100;
  localparam sdram_cmd_t CMD_AUTO_REFRESH = 4'b0001;

  localparam int unsigned BA_W  = 2;
  localparam int unsigned ROW_W = 12;
  localparam int unsigned COL_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACTIVATE,
    S_TRCD_WAIT,
    S_WR_SEQ,
    S_RD_SEQ,
    S_RELEASE,
    S_TRP_WAIT,
    S_REFRESH,
    S_TRFC_WAIT
  } disp_state_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_cmd_dispatch_if.sv
// Host request, sequencer handshake and SDRAM command bus of the dispatcher.
// master = dispatcher side, slave = host / sequencers / pins side.
interface sdram_cmd_dispatch_if;
  import sdram_pkg::*;

  logic                   init_done;
  logic                   req_valid;
  logic                   req_write;
  logic [21:0]            req_addr;
  logic                   req_ready;
  logic                   busy;
  logic                   wr_start;
  logic                   wr_done;
  logic                   wr_chip;
  logic                   rd_start;
  logic                   rd_done;
  logic                   rd_chip;
  sdram_cmd_t             sdram_cmd;
  logic [ROW_W-1:0]       sdram_addr;
  logic [BA_W-1:0]        sdram_ba;

  modport master (
    input  init_done, req_valid, req_write, req_addr, wr_done, wr_chip, rd_done, rd_chip,
    output req_ready, busy, wr_start, rd_start, sdram_cmd, sdram_addr, sdram_ba
  );

  modport slave (
    output init_done, req_valid, req_write, req_addr, wr_done, wr_chip, rd_done, rd_chip,
    input  req_ready, busy, wr_start, rd_start, sdram_cmd, sdram_addr, sdram_ba
  );

endinterface

// File: rtl/sdram_cmd_dispatch_refresh_timer.sv
// Periodic refresh request: raises refresh_pending every REF_INTERVAL enabled cycles.
// Expiry wins over a same-cycle ack so a refresh period is never lost.
module sdram_refresh_timer #(
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic ack,
  output logic refresh_pending
);

  localparam int unsigned CNT_W = $clog2(REF_INTERVAL);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic             expire;

  assign expire          = enable && (cnt_q == '0);
  assign refresh_pending = pending_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
    end else begin
      if (!enable || expire) cnt_q <= RELOAD;
      else                   cnt_q <= cnt_q - CNT_W'(1);
      pending_q <= expire || (pending_q && !ack);
    end
  end

endmodule

// File: rtl/sdram_cmd_dispatch.sv
// SDRAM front-end dispatcher: opens the row, hands the column phase to the rd/wr sequencers, refreshes.
// Accept-to-ACTIVE is 1 cycle; req_ready drops whenever busy, not initialised or a refresh is due.
module sdram_cmd_dispatch
  import sdram_pkg::*;
#(
  parameter int unsigned T_RCD        = 2,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RFC        = 7,
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic clk,
  input  logic n_rst,
  sdram_cmd_dispatch_if.master io
);

  localparam int unsigned CW = $clog2(max3(T_RCD, T_RP, T_RFC) + 1);
  // TRCD_WAIT covers T_RCD-1 cycles; ACTIVATE itself supplies the first one.
  localparam logic [CW-1:0] RCD_LOAD = CW'((T_RCD > 1) ? (T_RCD - 2) : 0);
  localparam logic [CW-1:0] RP_LOAD  = CW'(T_RP - 1);
  localparam logic [CW-1:0] RFC_LOAD = CW'(T_RFC - 1);

  disp_state_t       state_q;
  sdram_cmd_t        cmd_q;
  logic [ROW_W-1:0]  addr_q;
  logic [BA_W-1:0]   ba_q;
  logic [BA_W-1:0]   bank_q;
  logic [COL_W-1:0]  col_q;
  logic              write_q;
  logic              wr_start_q;
  logic              rd_start_q;
  logic              busy_q;
  logic [CW-1:0]     wait_q;
  logic              ref_pending;
  logic              ref_ack;
  logic              req_ready;

  assign req_ready = (state_q == S_IDLE) && io.init_done && !ref_pending;
  assign ref_ack   = (state_q == S_REFRESH);

  sdram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_refresh_timer (
    .clk             (clk),
    .n_rst           (n_rst),
    .enable          (io.init_done),
    .ack             (ref_ack),
    .refresh_pending (ref_pending)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      ba_q       <= '0;
      bank_q     <= '0;
      col_q      <= '0;
      write_q    <= 1'b0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      busy_q     <= 1'b0;
      wait_q     <= '0;
    end else begin
      cmd_q  <= CMD_NOP;
      addr_q <= '0;
      ba_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (ref_pending && io.init_done) begin
            state_q <= S_REFRESH;
            cmd_q   <= CMD_AUTO_REFRESH;
            busy_q  <= 1'b1;
          end else if (io.req_valid && req_ready) begin
            state_q <= S_ACTIVATE;
            cmd_q   <= CMD_ACTIVE;
            addr_q  <= io.req_addr[19:8];
            ba_q    <= io.req_addr[21:20];
            bank_q  <= io.req_addr[21:20];
            col_q   <= io.req_addr[7:0];
            write_q <= io.req_write;
            busy_q  <= 1'b1;
          end
        end
        S_ACTIVATE: begin
          if (T_RCD > 1) begin
            state_q <= S_TRCD_WAIT;
            wait_q  <= RCD_LOAD;
          end else begin
            state_q    <= write_q ? S_WR_SEQ : S_RD_SEQ;
            wr_start_q <= write_q;
            rd_start_q <= !write_q;
          end
        end
        S_TRCD_WAIT: begin
          if (wait_q == '0) begin
            state_q    <= write_q ? S_WR_SEQ : S_RD_SEQ;
            wr_start_q <= write_q;
            rd_start_q <= !write_q;
          end else begin
            wait_q <= wait_q - CW'(1);
          end
        end
        S_WR_SEQ: begin
          if (io.wr_chip) begin
            cmd_q  <= CMD_WRITE;
            addr_q <= {1'b0, 1'b1, 2'b00, col_q};
            ba_q   <= bank_q;
          end
          if (io.wr_done) begin
            state_q    <= S_RELEASE;
            wr_start_q <= 1'b0;
          end
        end
        S_RD_SEQ: begin
          if (io.rd_chip) begin
            cmd_q  <= CMD_READ;
            addr_q <= {1'b0, 1'b1, 2'b00, col_q};
            ba_q   <= bank_q;
          end
          if (io.rd_done) begin
            state_q    <= S_RELEASE;
            rd_start_q <= 1'b0;
          end
        end
        S_RELEASE: begin
          // Sequencer must drop done before the next access can start it again.
          if (!(write_q ? io.wr_done : io.rd_done)) begin
            state_q <= S_TRP_WAIT;
            wait_q  <= RP_LOAD;
          end
        end
        S_TRP_WAIT, S_TRFC_WAIT: begin
          if (wait_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            wait_q <= wait_q - CW'(1);
          end
        end
        S_REFRESH: begin
          state_q <= S_TRFC_WAIT;
          wait_q  <= RFC_LOAD;
        end
        default: begin
          state_q    <= S_IDLE;
          wr_start_q <= 1'b0;
          rd_start_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign io.req_ready  = req_ready;
  assign io.busy       = busy_q;
  assign io.wr_start   = wr_start_q;
  assign io.rd_start   = rd_start_q;
  assign io.sdram_cmd  = cmd_q;
  assign io.sdram_addr = addr_q;
  assign io.sdram_ba   = ba_q;

endmodule
